// File: rtl/led_alarm_pkg.sv
// Package shared by the LED alarm driver and its counters.
//   - FSM state encodings (2-bit, every code is used)
//   - default values for the top-level parameters
//   - width of the internal qualification, blink and hold-off counters
//   - slot indices of the three counter instances in the top module
package led_alarm_pkg;

    // Internal counters are 8 bits wide. Every parameter limit fits in
    // 1..255, so limit-1 always fits in this width.
    localparam int CTR_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_ALARM   = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam int DEF_QUAL_CYCLES    = 4;
    localparam int DEF_BLINK_HALF     = 8;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int DEF_CNT_W          = 8;

    // Slot of each counter in the top module's counter vectors.
    localparam int CTR_QUAL  = 0;
    localparam int CTR_BLINK = 1;
    localparam int CTR_HOLD  = 2;
    localparam int NUM_CTRS  = 3;

endpackage

// File: rtl/led_alarm_driver_cycle_counter.sv
// Clearable, enabled up-counter with a terminal-count flag.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   clr   : synchronous clear; takes priority over en
//   en    : increment on the next edge
//   limit : runtime terminal value
//   tc    : high while the current count equals limit
module cycle_counter
    import led_alarm_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/led_alarm_driver.sv
// LED alarm driver. Qualifies the combining stage's LED decision over
// consecutive cycles, latches an alarm that blinks the LED until an operator
// acknowledge, then waits out a hold-off before re-arming. Keeps a saturating
// count of alarms raised.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   led_req      : LED decision from the combining stage
//   ack          : operator acknowledge (level, honoured only in ALARM)
//   led_out      : registered LED drive
//   alarm_active : registered, high while in ALARM
//   alarm_count  : registered saturating count of alarms raised
module led_alarm_driver
    import led_alarm_pkg::*;
#(
    parameter int QUAL_CYCLES    = DEF_QUAL_CYCLES,
    parameter int BLINK_HALF     = DEF_BLINK_HALF,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_req,
    input  logic             ack,
    output logic             led_out,
    output logic             alarm_active,
    output logic [CNT_W-1:0] alarm_count
);

    // Terminal values, packed so the generate loop can slice them per slot.
    // The qualification counter is loaded with 1 on the IDLE->QUAL edge, so
    // reaching QUAL_CYCLES-1 while led_req is still high means QUAL_CYCLES
    // consecutive high samples.
    localparam logic [CTR_W-1:0] QUAL_LIM  = CTR_W'(QUAL_CYCLES - 1);
    localparam logic [CTR_W-1:0] BLINK_LIM = CTR_W'(BLINK_HALF - 1);
    localparam logic [CTR_W-1:0] HOLD_LIM  = CTR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [NUM_CTRS*CTR_W-1:0] LIMITS = {HOLD_LIM, BLINK_LIM, QUAL_LIM};

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             led_q;
    logic             led_d;
    logic             active_q;
    logic             active_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [NUM_CTRS-1:0] ctr_clr;
    logic [NUM_CTRS-1:0] ctr_en;
    logic [NUM_CTRS-1:0] ctr_tc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
            cycle_counter #(
                .W(CTR_W)
            ) u_ctr (
                .clk  (clk),
                .rst  (rst),
                .clr  (ctr_clr[gi]),
                .en   (ctr_en[gi]),
                .limit(LIMITS[gi*CTR_W +: CTR_W]),
                .tc   (ctr_tc[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        active_d = active_q;
        count_d  = count_q;
        // Counters sit cleared unless their state explicitly runs them, so
        // each one starts from 0 on entry to its state.
        ctr_clr  = '1;
        ctr_en   = '0;

        case (state_q)
            ST_IDLE: begin
                led_d    = 1'b0;
                active_d = 1'b0;
                if (led_req) begin
                    state_d           = ST_QUAL;
                    ctr_clr[CTR_QUAL] = 1'b0;
                    ctr_en[CTR_QUAL]  = 1'b1;
                end
            end

            ST_QUAL: begin
                led_d    = 1'b0;
                active_d = 1'b0;
                if (!led_req) begin
                    state_d = ST_IDLE;
                end else if (ctr_tc[CTR_QUAL]) begin
                    state_d  = ST_ALARM;
                    led_d    = 1'b1;
                    active_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    ctr_clr[CTR_QUAL] = 1'b0;
                    ctr_en[CTR_QUAL]  = 1'b1;
                end
            end

            ST_ALARM: begin
                // led_req is deliberately not looked at: the alarm is latched.
                if (ack) begin
                    state_d  = ST_HOLDOFF;
                    led_d    = 1'b0;
                    active_d = 1'b0;
                end else begin
                    active_d = 1'b1;
                    if (ctr_tc[CTR_BLINK]) begin
                        led_d = ~led_q;
                    end else begin
                        ctr_clr[CTR_BLINK] = 1'b0;
                        ctr_en[CTR_BLINK]  = 1'b1;
                    end
                end
            end

            ST_HOLDOFF: begin
                led_d    = 1'b0;
                active_d = 1'b0;
                if (ctr_tc[CTR_HOLD]) begin
                    state_d = ST_IDLE;
                end else begin
                    ctr_clr[CTR_HOLD] = 1'b0;
                    ctr_en[CTR_HOLD]  = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                led_d    = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            led_q    <= 1'b0;
            active_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            active_q <= active_d;
            count_q  <= count_d;
        end
    end

    assign led_out      = led_q;
    assign alarm_active = active_q;
    assign alarm_count  = count_q;

endmodule

// File: tb/tb_led_alarm_driver.sv
module tb_led_alarm_driver;

    logic       clk;
    logic       rst;
    logic       led_req;
    logic       ack;
    logic       led_out;
    logic       alarm_active;
    logic [7:0] alarm_count;

    typedef struct packed {
        logic       led;
        logic       act;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    led_alarm_driver #(
        .QUAL_CYCLES   (4),
        .BLINK_HALF    (8),
        .HOLDOFF_CYCLES(16),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_req     (led_req),
        .ack         (ack),
        .led_out     (led_out),
        .alarm_active(alarm_active),
        .alarm_count (alarm_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, and settle 1 time unit after it.
    task automatic cycle(input logic r, input logic a);
        led_req = r;
        ack     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; led_req = 1'b0; ack = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd0});
            if (i == 1) begin
                @(posedge clk);
                #1;
            end
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL reset[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         i, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok reset[%0d] led=%0b act=%0b cnt=%0d", i, led_out, alarm_active, alarm_count);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 3 high samples then low never qualifies; a second run of 3 only
    // stays quiet if the low sample truly restarted qualification.
    task automatic test_qual_reject();
        logic [8:0] pat;
        exp_t e;
        pat = 9'b001110111;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd0});
            cycle(pat[i], 1'b0);
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL reject[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         i, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok reject[%0d] req=%0b led=%0b act=%0b cnt=%0d", i, pat[i], led_out, alarm_active, alarm_count);
            end
        end
    endtask

    // Alarm raises after edge 4; then LED is on for 8 edges, off for 8, ...
    // led_req is dropped partway through and must not matter.
    task automatic test_alarm_blink();
        exp_t e;
        for (int k = -3; k <= 40; k++) begin
            if (k <= 0)
                exp_q.push_back('{led: (k == 0), act: (k == 0), cnt: (k == 0) ? 8'd1 : 8'd0});
            else
                exp_q.push_back('{led: ((k / 8) % 2 == 0), act: 1'b1, cnt: 8'd1});
            cycle((k < 10), 1'b0);
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL blink[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         k, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok blink[%0d] led=%0b act=%0b cnt=%0d", k, led_out, alarm_active, alarm_count);
            end
        end
    endtask

    // ack together with led_req wins; 16 hold-off edges ignore led_req; the
    // edge leaving hold-off plus 4 qualification edges re-raise the alarm.
    // A second, multi-cycle ack then returns the block to IDLE.
    task automatic test_ack_holdoff();
        exp_t e;
        for (int k = 0; k <= 40; k++) begin
            logic r;
            logic a;
            r = (k <= 20);
            a = (k == 0) || (k >= 22 && k <= 24);
            if (k < 20)
                exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd1});
            else if (k <= 21)
                exp_q.push_back('{led: 1'b1, act: 1'b1, cnt: 8'd2});
            else
                exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd2});
            cycle(r, a);
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL ack_holdoff[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         k, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok ack_holdoff[%0d] req=%0b ack=%0b led=%0b act=%0b cnt=%0d",
                         k, r, a, led_out, alarm_active, alarm_count);
            end
        end
    endtask

    // ack high in IDLE and QUAL has no effect; the alarm raises on edge 4.
    task automatic test_ignored_ack();
        exp_t e;
        for (int k = 0; k < 7; k++) begin
            logic r;
            logic a;
            r = (k >= 2);
            a = (k < 5);
            if (k < 5)
                exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd2});
            else
                exp_q.push_back('{led: 1'b1, act: 1'b1, cnt: 8'd3});
            cycle(r, a);
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL ignored_ack[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         k, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok ignored_ack[%0d] req=%0b ack=%0b led=%0b act=%0b cnt=%0d",
                         k, r, a, led_out, alarm_active, alarm_count);
            end
        end
    endtask

    // Reset asserted between edges while the alarm is lit must clear the
    // outputs without waiting for a clock edge.
    task automatic test_async_reset();
        exp_t e;
        led_req = 1'b0;
        ack     = 1'b0;
        #2;
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd0});
            if (k == 0) begin
                #1;
            end else if (k == 1) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                cycle(1'b0, 1'b0);
            end
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL async_reset[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         k, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok async_reset[%0d] led=%0b act=%0b cnt=%0d", k, led_out, alarm_active, alarm_count);
            end
        end
    endtask

    // 257 full alarm/ack/hold-off rounds; the count must stop at 255.
    task automatic test_saturation();
        exp_t e;
        for (int i = 1; i <= 257; i++) begin
            for (int j = 0; j < 3; j++) cycle(1'b1, 1'b0);
            exp_q.push_back('{led: 1'b1, act: 1'b1, cnt: (i > 255) ? 8'd255 : 8'(i)});
            cycle(1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
                bad++;
                $display("FAIL saturate[%0d]: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                         i, led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
            end else begin
                $display("ok saturate[%0d] cnt=%0d", i, alarm_count);
            end
            cycle(1'b0, 1'b1);
            for (int j = 0; j < 16; j++) cycle(1'b0, 1'b0);
        end
        exp_q.push_back('{led: 1'b0, act: 1'b0, cnt: 8'd255});
        cycle(1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (led_out !== e.led || alarm_active !== e.act || alarm_count !== e.cnt) begin
            bad++;
            $display("FAIL saturate_idle: got led=%0b act=%0b cnt=%0d, expected led=%0b act=%0b cnt=%0d",
                     led_out, alarm_active, alarm_count, e.led, e.act, e.cnt);
        end else begin
            $display("ok saturate_idle cnt=%0d", alarm_count);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_qual_reject();
        test_alarm_blink();
        test_ack_holdoff();
        test_ignored_ack();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
